// File: rtl/wb_sram_arbiter_pkg.sv
// Shared definitions for the Wishbone SRAM arbiter: FSM encoding, master
// count and the round-robin search used by the picker.
package wb_pkg;

    localparam int unsigned NUM_MASTERS = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // First requester found searching upward from last+1, modulo 3.
    // The result is meaningless when req is all zero; callers check valid.
    function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] w_win;
        w_win = 2'd0;
        case (last)
            2'd0:    w_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        return w_win;
    endfunction

endpackage

// File: rtl/wb_sram_arbiter_rr_pick.sv
// Combinational round-robin picker: request vector plus last owner in,
// winner index and request-present flag out.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [1:0]             i_last,
    output logic [1:0]             o_winner,
    output logic                   o_valid
);

    assign o_winner = rr_next(i_req, i_last);
    assign o_valid  = |i_req;

endmodule

// File: rtl/wb_sram_arbiter.sv
// Three-master to one-slave Wishbone arbiter for the shared SRAM.
// Round-robin grant held for the whole cyc, plus a stalled-strobe watchdog
// that turns a hung slave into an error to the current owner.
module wb_sram_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned adr_width = 32,
    parameter int unsigned timeout   = 255,
    parameter int unsigned tmo_width = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    input  logic                 m2_cyc_i,
    input  logic                 m2_stb_i,
    input  logic                 m2_we_i,
    input  logic [adr_width-1:0] m2_adr_i,
    input  logic [3:0]           m2_sel_i,
    input  logic [31:0]          m2_dat_i,
    output logic [31:0]          m2_dat_o,
    output logic                 m2_ack_o,
    output logic                 m2_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [adr_width-1:0] s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [2:0]           grant_o
);

    localparam logic                 TMO_EN   = (timeout != 0);
    localparam logic [tmo_width-1:0] TMO_LAST = tmo_width'((timeout == 0) ? 0 : timeout - 1);

    logic [NUM_MASTERS-1:0] w_cyc, w_stb, w_we;
    logic [adr_width-1:0]   w_adr [NUM_MASTERS];
    logic [3:0]             w_sel [NUM_MASTERS];
    logic [31:0]            w_dat [NUM_MASTERS];

    logic [0:0]           r_state;
    logic [1:0]           r_grant_idx;
    logic [1:0]           r_last;
    logic [tmo_width-1:0] r_cnt;
    logic                 r_err_pulse;

    logic                   w_own, w_stall, w_pick_valid;
    logic [1:0]             w_winner;
    logic                   w_g_cyc, w_g_stb, w_g_we;
    logic [adr_width-1:0]   w_g_adr;
    logic [3:0]             w_g_sel;
    logic [31:0]            w_g_dat;
    logic [NUM_MASTERS-1:0] w_ack, w_err;

    assign w_cyc    = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
    assign w_stb    = {m2_stb_i, m1_stb_i, m0_stb_i};
    assign w_we     = {m2_we_i,  m1_we_i,  m0_we_i};
    assign w_adr[0] = m0_adr_i;
    assign w_adr[1] = m1_adr_i;
    assign w_adr[2] = m2_adr_i;
    assign w_sel[0] = m0_sel_i;
    assign w_sel[1] = m1_sel_i;
    assign w_sel[2] = m2_sel_i;
    assign w_dat[0] = m0_dat_i;
    assign w_dat[1] = m1_dat_i;
    assign w_dat[2] = m2_dat_i;

    wb_rr_pick u_pick (
        .i_req    (w_cyc),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_pick_valid)
    );

    assign w_own = (r_state == ST_OWN);

    // Select the granted master's request signals.
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_sel = '0;
        w_g_dat = '0;
        for (int unsigned n = 0; n < NUM_MASTERS; n++) begin
            if (r_grant_idx == 2'(n)) begin
                w_g_cyc = w_cyc[n];
                w_g_stb = w_stb[n];
                w_g_we  = w_we[n];
                w_g_adr = w_adr[n];
                w_g_sel = w_sel[n];
                w_g_dat = w_dat[n];
            end
        end
    end

    // The error pulse aborts the slave transfer by dropping cyc/stb for its cycle.
    assign s_cyc_o = w_own & w_g_cyc & ~r_err_pulse;
    assign s_stb_o = w_own & w_g_stb & ~r_err_pulse;
    assign s_we_o  = w_own & w_g_we;
    assign s_adr_o = w_own ? w_g_adr : '0;
    assign s_sel_o = w_own ? w_g_sel : '0;
    assign s_dat_o = w_own ? w_g_dat : '0;

    assign grant_o = w_own ? (3'b001 << r_grant_idx) : 3'b000;

    // Route slave responses to the owner only; a watchdog error overrides an ack.
    always_comb begin
        w_ack = '0;
        w_err = '0;
        for (int unsigned n = 0; n < NUM_MASTERS; n++) begin
            if (w_own && (r_grant_idx == 2'(n))) begin
                w_ack[n] = s_ack_i & ~r_err_pulse;
                w_err[n] = s_err_i | r_err_pulse;
            end
        end
    end

    assign m0_ack_o = w_ack[0];
    assign m1_ack_o = w_ack[1];
    assign m2_ack_o = w_ack[2];
    assign m0_err_o = w_err[0];
    assign m1_err_o = w_err[1];
    assign m2_err_o = w_err[2];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;

    assign w_stall = s_stb_o & ~s_ack_i & ~s_err_i;

    // Ownership FSM: arbitrate in IDLE, hold the grant until the owner drops cyc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= 2'd0;
            r_last      <= 2'd2;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= ST_OWN;
                        r_grant_idx <= w_winner;
                        r_last      <= w_winner;
                    end
                end
                default: begin
                    if (!w_g_cyc) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Watchdog: count stalled strobe cycles, fire a one-cycle error at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_err_pulse <= 1'b0;
        end else if (!TMO_EN) begin
            r_cnt       <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_stall) begin
                if (r_cnt == TMO_LAST) begin
                    r_err_pulse <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
